// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parameterised VGA raster timing generator and pixel output stage.
// Runs a 12-bit h/v counter pair, pulls pixels over valid/ready during the
// active region and drives registered RGB, sync and blanking pins.
// Optional feature macro: VGA_UNDERFLOW_CNT_EN builds the 16-bit saturating
// underflow counter; without it underflow_cnt is tied to 0.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic        frame_start,
  output logic        underflow,
  input  logic        underflow_clr,
  output logic [15:0] underflow_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Region boundaries in counter units; sync is [S, E).
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] H_SS   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SE   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] V_SS   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SE   = 12'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON  = (HS_POL != 0);
  localparam logic HS_OFF = !HS_ON;
  localparam logic VS_ON  = (VS_POL != 0);
  localparam logic VS_OFF = !VS_ON;

  logic [11:0] h_cnt, v_cnt;
  logic        h_end, v_end;
  logic        active, hs_raw, vs_raw;

  assign h_end  = (h_cnt == H_LAST);
  assign v_end  = (v_cnt == V_LAST);
  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_raw = (h_cnt >= H_SS) && (h_cnt < H_SE);
  assign vs_raw = (v_cnt >= V_SS) && (v_cnt < V_SE);

  // Ready depends only on raster position, never on pix_valid, so the source
  // cannot stall the raster.
  assign pix_ready = enable && active;

  // Raster counters: free-run while enabled, parked at (0,0) while disabled so
  // a re-enable always starts a fresh frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!enable) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_end) begin
      h_cnt <= '0;
      v_cnt <= v_end ? '0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  // Output stage: every pin is one clock behind the counters, so the pixel
  // accepted at a position and that position's sync/blank land together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {vga_r, vga_g, vga_b} <= '0;
      vga_hs      <= HS_OFF;
      vga_vs      <= VS_OFF;
      vga_blank_n <= 1'b0;
      vga_sync_n  <= 1'b1;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      {vga_r, vga_g, vga_b} <= (pix_ready && pix_valid) ? pix_data : 24'h0;
      vga_hs      <= (enable && hs_raw) ? HS_ON : HS_OFF;
      vga_vs      <= (enable && vs_raw) ? VS_ON : VS_OFF;
      vga_blank_n <= pix_ready;
      vga_sync_n  <= 1'b1;
      frame_start <= enable && (h_cnt == '0) && (v_cnt == '0);
      underflow   <= pix_ready && !pix_valid;
    end
  end

`ifdef VGA_UNDERFLOW_CNT_EN
  // Miss counter: counts registered underflow pulses, saturates, clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      underflow_cnt <= '0;
    else if (underflow_clr)
      underflow_cnt <= '0;
    else if (underflow && (underflow_cnt != 16'hFFFF))
      underflow_cnt <= underflow_cnt + 16'd1;
  end
`else
  logic unused_clr;
  assign unused_clr    = underflow_clr;
  assign underflow_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small-geometry instance checked cycle by cycle
// against a raster model through an expectation queue, plus a large-geometry
// instance with inverted polarities used for sync polarity and counter
// saturation.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // small geometry instance
  logic        reset_n = 1'b0, enable = 1'b0, pix_valid = 1'b0, underflow_clr = 1'b0;
  logic [23:0] pix_data = 24'h0;
  logic        pix_ready;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start, underflow;
  logic [15:0] underflow_cnt;

  // polarity / saturation instance
  logic        rst2_n = 1'b0, en2 = 1'b0, val2 = 1'b0, clr2 = 1'b0;
  logic        prdy2;
  logic [7:0]  r2, g2, b2;
  logic        hs2, vs2, bl2, sn2, fs2, uf2;
  logic [15:0] cnt2;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(0)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_sync_n(vga_sync_n), .frame_start(frame_start), .underflow(underflow),
    .underflow_clr(underflow_clr), .underflow_cnt(underflow_cnt)
  );

  vga_timing_gen #(
    .H_ACTIVE(1000), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(66), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1)
  ) u_pol (
    .clk(clk), .reset_n(rst2_n), .enable(en2),
    .pix_data(24'h5a5a5a), .pix_valid(val2), .pix_ready(prdy2),
    .vga_r(r2), .vga_g(g2), .vga_b(b2),
    .vga_hs(hs2), .vga_vs(vs2), .vga_blank_n(bl2),
    .vga_sync_n(sn2), .frame_start(fs2), .underflow(uf2),
    .underflow_clr(clr2), .underflow_cnt(cnt2)
  );

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs, vs, bl, sn, fs, uf;
    logic [15:0] cnt;
    logic        rdy;
  } exp_t;

  localparam exp_t RST_V = '{rgb: 24'h0, hs: 1'b1, vs: 1'b1, bl: 1'b0, sn: 1'b1,
                             fs: 1'b0, uf: 1'b0, cnt: 16'h0, rdy: 1'b0};

  exp_t        exp_q[$];
  int          n_run = 0, n_fail = 0;
  int          mh = 0, mv = 0;        // model raster position
  logic        m_uf = 1'b0;           // model underflow pin
  logic [15:0] m_cnt = 16'h0;         // model miss counter
  logic        lrdy = 1'b0;           // model ready of the last driven cycle
  logic        rdy_obs = 1'b0;        // pix_ready sampled before the edge
  logic [23:0] px = 24'h000101;       // next pixel of the source
  int          pol_miss = 0;

  function automatic exp_t pins();
    pins = {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n,
            frame_start, underflow, underflow_cnt, rdy_obs};
  endfunction

  // Drive one cycle, push the expected pin state after the edge, advance model.
  task automatic drv(input logic en, input logic val, input logic [23:0] d, input logic clr);
    exp_t e;
    logic rdy;
    enable = en; pix_valid = val; pix_data = d; underflow_clr = clr;
    rdy   = en && (mh < 4) && (mv < 3);
    e.rgb = (rdy && val) ? d : 24'h0;
    e.hs  = !(en && mh >= 5 && mh < 7);
    e.vs  = !(en && mv == 4);
    e.bl  = rdy;
    e.sn  = 1'b1;
    e.fs  = en && mh == 0 && mv == 0;
    e.uf  = rdy && !val;
`ifdef VGA_UNDERFLOW_CNT_EN
    if (clr) e.cnt = 16'h0;
    else if (m_uf && m_cnt != 16'hFFFF) e.cnt = m_cnt + 16'd1;
    else e.cnt = m_cnt;
`else
    e.cnt = 16'h0;
`endif
    e.rdy = rdy;
    m_uf = e.uf; m_cnt = e.cnt; lrdy = rdy;
    exp_q.push_back(e);
    if (!en) begin mh = 0; mv = 0; end
    else if (mh == 7) begin mh = 0; mv = (mv == 5) ? 0 : mv + 1; end
    else mh = mh + 1;
    #1 rdy_obs = pix_ready;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    exp_t o;
    repeat (2) @(posedge clk);
    #1 rdy_obs = pix_ready;
    o = pins();
    n_run++;
    if (o !== RST_V) begin
      n_fail++; $display("FAIL reset_state got=%h exp=%h", o, RST_V);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_raster;
    exp_t e, o;
    int bl_n = 0, hs_n = 0, vs_n = 0, fs_n = 0;
    for (int i = 0; i < 96; i++) begin
      drv(1'b1, 1'b1, px, 1'b0);
      if (lrdy) px = px + 24'h010203;
      e = exp_q.pop_front(); o = pins();
      n_run++;
      if (o !== e) begin
        n_fail++; $display("FAIL raster cyc=%0d got=%h exp=%h", i, o, e);
      end
      if (i < 48) begin
        bl_n += int'(vga_blank_n); hs_n += int'(!vga_hs);
        vs_n += int'(!vga_vs);     fs_n += int'(frame_start);
      end
    end
    n_run++;
    if (bl_n != 12) begin n_fail++; $display("FAIL blank_count got=%0d exp=12", bl_n); end
    n_run++;
    if (hs_n != 12) begin n_fail++; $display("FAIL hs_low_count got=%0d exp=12", hs_n); end
    n_run++;
    if (vs_n != 8) begin n_fail++; $display("FAIL vs_low_count got=%0d exp=8", vs_n); end
    n_run++;
    if (fs_n != 1) begin n_fail++; $display("FAIL frame_start_count got=%0d exp=1", fs_n); end
  endtask

  task automatic test_underflow;
    exp_t e, o;
    int uf_n = 0;
    logic miss;
    for (int i = 0; i < 48; i++) begin
      miss = (mh == 2 && mv == 1);
      drv(1'b1, !miss, px, 1'b0);
      if (lrdy && !miss) px = px + 24'h010203;
      e = exp_q.pop_front(); o = pins();
      n_run++;
      if (o !== e) begin
        n_fail++; $display("FAIL underflow cyc=%0d got=%h exp=%h", i, o, e);
      end
      uf_n += int'(underflow);
    end
    n_run++;
    if (uf_n != 1) begin n_fail++; $display("FAIL underflow_pulses got=%0d exp=1", uf_n); end
  endtask

  task automatic test_enable;
    exp_t e, o;
    int fs_lat = -1;
    for (int i = 0; i < 19 + 5 + 48; i++) begin
      logic en;
      en = !(i >= 19 && i < 24);
      drv(en, 1'b1, px, 1'b0);
      if (lrdy) px = px + 24'h010203;
      e = exp_q.pop_front(); o = pins();
      n_run++;
      if (o !== e) begin
        n_fail++; $display("FAIL enable cyc=%0d got=%h exp=%h", i, o, e);
      end
      if (i >= 24 && fs_lat < 0 && frame_start) fs_lat = i - 23;
    end
    n_run++;
    if (fs_lat < 1 || fs_lat > 2) begin
      n_fail++; $display("FAIL reenable_frame_start got=%0d exp=1..2 clocks", fs_lat);
    end
  endtask

  task automatic test_clear;
    exp_t e, o;
    for (int i = 0; i < 16; i++) begin
      logic val;
      val = (i >= 3);
      drv(1'b1, val, px, i == 2);
      if (lrdy && val) px = px + 24'h010203;
      e = exp_q.pop_front(); o = pins();
      n_run++;
      if (o !== e) begin
        n_fail++; $display("FAIL clear cyc=%0d got=%h exp=%h", i, o, e);
      end
    end
  endtask

  task automatic test_reset_midline;
    exp_t e, o, rv;
    for (int i = 0; i < 10; i++) begin
      drv(1'b1, 1'b1, px, 1'b0);
      if (lrdy) px = px + 24'h010203;
      void'(exp_q.pop_front());
    end
    #2 reset_n = 1'b0;
    #1 rdy_obs = pix_ready;
    o = pins();
    rv = RST_V; rv.rdy = 1'b1;   // counters at (0,0) with enable high
    n_run++;
    if (o !== rv) begin
      n_fail++; $display("FAIL async_reset got=%h exp=%h", o, rv);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    mh = 0; mv = 0; m_uf = 1'b0; m_cnt = 16'h0;
    for (int i = 0; i < 12; i++) begin
      drv(1'b1, 1'b1, px, 1'b0);
      if (lrdy) px = px + 24'h010203;
      e = exp_q.pop_front(); o = pins();
      n_run++;
      if (o !== e) begin
        n_fail++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", i, o, e);
      end
    end
  endtask

  task automatic test_polarity;
    logic exp_hs;
    n_run++;
    if (hs2 !== 1'b0) begin n_fail++; $display("FAIL pol_reset_hs got=%b exp=0", hs2); end
    n_run++;
    if (vs2 !== 1'b0) begin n_fail++; $display("FAIL pol_reset_vs got=%b exp=0", vs2); end
    rst2_n = 1'b1; en2 = 1'b1; val2 = 1'b0;
    for (int k = 1; k <= 1004; k++) begin
      @(posedge clk); #1;
      if (uf2) pol_miss++;
      exp_hs = (k - 1 >= 1001) && (k - 1 <= 1002);
      n_run++;
      if (hs2 !== exp_hs || vs2 !== 1'b0) begin
        n_fail++; $display("FAIL pol_sync k=%0d got hs=%b vs=%b exp hs=%b vs=0", k, hs2, vs2, exp_hs);
      end
    end
  endtask

  task automatic test_saturate;
`ifdef VGA_UNDERFLOW_CNT_EN
    logic seen = 1'b0;
    int   len = 0;
    for (int k = 0; k < 75000 && pol_miss < 65600; k++) begin
      @(posedge clk); #1;
      if (uf2) pol_miss++;
    end
    n_run++;
    if (pol_miss < 65600) begin n_fail++; $display("FAIL sat_timeout got=%0d misses exp>=65600", pol_miss); end
    @(posedge clk); #1;
    n_run++;
    if (cnt2 !== 16'hFFFF) begin n_fail++; $display("FAIL sat_count got=%h exp=ffff", cnt2); end
    for (int k = 0; k < 5000 && !seen; k++) begin
      @(posedge clk); #1;
      if (vs2) seen = 1'b1;
    end
    n_run++;
    if (!seen) begin n_fail++; $display("FAIL pol_vs_timeout got=none exp=vs high"); end
    while (vs2 && len < 2000) begin @(posedge clk); #1; len++; end
    n_run++;
    if (len != 1004) begin n_fail++; $display("FAIL pol_vs_width got=%0d exp=1004", len); end
    n_run++;
    if (cnt2 !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got=%h exp=ffff", cnt2); end
    clr2 = 1'b1;
    @(posedge clk); #1;
    clr2 = 1'b0;
    n_run++;
    if (cnt2 !== 16'h0) begin n_fail++; $display("FAIL sat_clear got=%h exp=0", cnt2); end
`else
    int m0;
    m0 = pol_miss;
    clr2 = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (uf2) pol_miss++;
      clr2 = (k % 7 == 0);
    end
    n_run++;
    if (pol_miss == m0) begin n_fail++; $display("FAIL nocnt_misses got=0 exp>0"); end
    n_run++;
    if (cnt2 !== 16'h0) begin n_fail++; $display("FAIL nocnt_value got=%h exp=0", cnt2); end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_raster();
    test_underflow();
    test_enable();
    test_clear();
    test_reset_midline();
    test_polarity();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
